// File: rtl/line_beat_serializer_pkg.sv
// Shared cache read-path definitions for the line-to-beat serializer:
// default geometry, derived-constant helpers and the FSM state type.
package line_beat_serializer_pkg;

    localparam int LINELEN_DEF = 512;
    localparam int BEATLEN_DEF = 64;
    localparam int PA_BITS_DEF = 34;

    typedef enum logic {IDLE, SEND} statetype;

    function automatic int calcBpl(input int lineLen, input int beatLen);
        return lineLen / beatLen;
    endfunction

    // A one-beat line still needs a one-bit counter so the port never collapses to zero width.
    function automatic int calcLogBpl(input int lineLen, input int beatLen);
        return (lineLen / beatLen > 1) ? $clog2(lineLen / beatLen) : 1;
    endfunction

    function automatic int calcLogBeatBytes(input int beatLen);
        return $clog2(beatLen / 8);
    endfunction

    function automatic int calcLogLineBytes(input int lineLen);
        return $clog2(lineLen / 8);
    endfunction

    localparam int BPL          = calcBpl(LINELEN_DEF, BEATLEN_DEF);
    localparam int LOGBPL       = calcLogBpl(LINELEN_DEF, BEATLEN_DEF);
    localparam int LOGBEATBYTES = calcLogBeatBytes(BEATLEN_DEF);
    localparam int LOGLINEBYTES = calcLogLineBytes(LINELEN_DEF);

endpackage

// File: rtl/line_beat_serializer_beat_counter.sv
// Beat index counter: synchronous reset and clear, count enable, and a
// terminal flag when the index reaches the last beat of the line.
module beat_counter #(
    parameter int WIDTH = 3,
    parameter int LAST  = 7
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;

    // Clear outranks enable so the last-beat handshake rewinds instead of overflowing.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == WIDTH'(LAST));

endmodule

// File: rtl/line_beat_serializer.sv
// Holds one cache line from the way-select OR stage and streams it out as
// little-endian bus beats with a valid/ready handshake.
module line_beat_serializer
    import line_beat_serializer_pkg::*;
#(
    parameter int LINELEN = LINELEN_DEF,
    parameter int BEATLEN = BEATLEN_DEF,
    parameter int PA_BITS = PA_BITS_DEF,
    localparam int LOGBPL = calcLogBpl(LINELEN, BEATLEN)
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_flush,
    input  logic               i_lineValid,
    output logic               o_lineReady,
    input  logic [LINELEN-1:0] i_lineData,
    input  logic [PA_BITS-1:0] i_lineAdr,
    output logic               o_beatValid,
    input  logic               i_beatReady,
    output logic [BEATLEN-1:0] o_beatData,
    output logic [PA_BITS-1:0] o_beatAdr,
    output logic [LOGBPL-1:0]  o_beatCount,
    output logic               o_beatLast,
    output logic               o_busy
);

    localparam int LAST_BEAT    = calcBpl(LINELEN, BEATLEN) - 1;
    localparam int LOG_BEAT_BYT = calcLogBeatBytes(BEATLEN);
    localparam int LOG_LINE_BYT = calcLogLineBytes(LINELEN);
    localparam logic [PA_BITS-1:0] ADR_MASK =
        ~((PA_BITS'(1) << LOG_LINE_BYT) - PA_BITS'(1));

    statetype           r_state;
    logic               r_beatValid;
    logic [LINELEN-1:0] r_lineData;
    logic [PA_BITS-1:0] r_lineAdr;

    logic [LOGBPL-1:0]  w_beatCount;
    logic               w_terminal;
    logic               w_handshake;
    logic               w_lastDone;
    logic               w_lineReady;
    logic               w_capture;

    assign w_handshake = r_beatValid & i_beatReady;
    assign w_lastDone  = w_handshake & w_terminal;
    // Accepting in the last-beat handshake cycle is what removes the bubble between lines.
    assign w_lineReady = ~i_flush & ((r_state == IDLE) | ((r_state == SEND) & w_lastDone));
    assign w_capture   = w_lineReady & i_lineValid;

    beat_counter #(
        .WIDTH (LOGBPL),
        .LAST  (LAST_BEAT)
    ) u_beatCounter (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_clear    (i_flush | w_lastDone),
        .i_enable   (w_handshake),
        .o_count    (w_beatCount),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_state     <= IDLE;
            r_beatValid <= 1'b0;
            r_lineData  <= '0;
            r_lineAdr   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_capture) begin
                        r_lineData  <= i_lineData;
                        r_lineAdr   <= i_lineAdr & ADR_MASK;
                        r_state     <= SEND;
                        r_beatValid <= 1'b1;
                    end
                end
                SEND: begin
                    if (w_capture) begin
                        r_lineData <= i_lineData;
                        r_lineAdr  <= i_lineAdr & ADR_MASK;
                    end else if (w_lastDone) begin
                        r_state     <= IDLE;
                        r_beatValid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_beatValid <= 1'b0;
                end
            endcase
        end
    end

    assign o_lineReady = w_lineReady;
    assign o_beatValid = r_beatValid;
    assign o_beatData  = r_lineData[int'(w_beatCount) * BEATLEN +: BEATLEN];
    assign o_beatAdr   = r_lineAdr | (PA_BITS'(w_beatCount) << LOG_BEAT_BYT);
    assign o_beatCount = w_beatCount;
    assign o_beatLast  = r_beatValid & w_terminal;
    assign o_busy      = (r_state == SEND);

endmodule

// File: doc/line_beat_serializer.md
Name: line_beat_serializer

Overview:
- Downstream of the way-select OR stage in the cache read path. That stage ORs the hit-masked way rows into one full cache line.
- This block captures that line plus its line address and emits it as consecutive bus-width beats with a valid/ready handshake.
- Consumers: the bus writeback path (dirty evict) and the sub-line read path.
- Single-line holding register, so a new line can be accepted in the same cycle the last beat of the previous line is accepted.

Parameters:
- LINELEN, 512, cache line width in bits; power of two, multiple of BEATLEN.
- BEATLEN, 64, beat width in bits; power of two, ≥ 8.
- PA_BITS, 34, physical address width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- Flush  input  1  abort the current line; synchronous, same priority as reset for datapath state.
- LineValid  input  1  LineData/LineAdr valid from the way-select OR stage.
- LineReady  output  1  block can accept a line this cycle.
- LineData  input  LINELEN  ORed way data.
- LineAdr  input  PA_BITS  line base address; low log2(LINELEN/8) bits are ignored.
- BeatValid  output  1  BeatData/BeatAdr valid.
- BeatReady  input  1  consumer accepts the beat.
- BeatData  output  BEATLEN  current beat, little-endian: beat k = LineData[k*BEATLEN +: BEATLEN].
- BeatAdr  output  PA_BITS  {LineAdr[PA_BITS-1:LOGLINEBYTES], BeatCount, LOGBEATBYTES zeros}.
- BeatCount  output  LOGBPL  index of the current beat.
- BeatLast  output  1  BeatValid & (BeatCount == BPL-1).
- Busy  output  1  a line is held (state SEND).

Behaviour:
- Derived constants: BPL = LINELEN/BEATLEN; LOGBPL = log2(BPL), minimum 1; LOGBEATBYTES = log2(BEATLEN/8); LOGLINEBYTES = log2(LINELEN/8).
- States: IDLE, SEND. Reset or Flush → IDLE, BeatCount=0, held line and address registers=0.
- Reset values: LineReady=1, BeatValid=0, BeatLast=0, Busy=0, BeatData=0, BeatAdr=0, BeatCount=0.
- IDLE:
  - LineReady=1, BeatValid=0.
  - LineValid → capture LineData and LineAdr, BeatCount=0, go to SEND.
  - First beat is valid the cycle after capture (1-cycle latency); no combinational path from LineData to BeatData.
- SEND:
  - BeatValid=1; BeatData/BeatAdr are driven from the held registers selected by BeatCount.
  - BeatValid & !BeatReady → hold all outputs stable. Data and address must not change while the beat is stalled.
  - BeatValid & BeatReady & !BeatLast → BeatCount+1.
  - BeatValid & BeatReady & BeatLast:
    - If LineValid: capture the new line, BeatCount=0, stay in SEND (back-to-back, no bubble).
    - Otherwise: go to IDLE, BeatCount=0.
- LineReady = IDLE | (SEND & BeatLast & BeatReady). This is a combinational path from BeatReady, and it is permitted.
- LineValid while LineReady=0 is ignored; the upstream stage must hold the line.
- BeatCount wraps only via the explicit clear on the last beat; it never counts past BPL-1.
- Flush in any state:
  - Next cycle IDLE, BeatValid=0.
  - A beat handshaking in the same cycle as Flush is considered delivered.
  - A LineValid in the same cycle as Flush is dropped; LineReady is forced to 0 when Flush=1.
- Reset mid-line: same as Flush; all partially sent beats are abandoned.
- BPL=1 (LINELEN==BEATLEN): every beat is BeatLast; BeatCount is held at 0.

Decomposition:
- Shared cache package holds:
  - constants BPL, LOGBPL, LOGBEATBYTES, LOGLINEBYTES as functions of LINELEN/BEATLEN;
  - the state enum type statetype {IDLE, SEND}.
- One sub-module, beat_counter: LOGBPL-bit up-counter with synchronous reset, enable and clear, and a terminal-count output (Count==BPL-1).
- The beat mux is an indexed part-select; no separate module.

Test Plan:
- Single line, BeatReady=1 continuously; LineAdr=0x2_0000_0047, LineData beat k = 64'h1111_1111_1111_1111*k:
  - BeatValid for exactly 8 consecutive cycles, starting 1 cycle after capture.
  - BeatAdr = 0x2_0000_0040 + 8k; BeatLast only at k=7.
  - Then IDLE with LineReady=1.
- Backpressure: BeatReady low for 3 cycles at k=2 → BeatData, BeatAdr and BeatCount hold at beat 2; total transfer takes 11 cycles.
- Back-to-back lines A then B, with LineValid held high → B is accepted in A's BeatLast handshake cycle; B beat 0 appears the next cycle; 16 beats with no bubble.
- Flush at k=4 while BeatReady=1 → beat 4 counted delivered; next cycle BeatValid=0, BeatCount=0, LineReady=1; a simultaneous LineValid is not captured.
- Synchronous reset asserted mid-line at k=5 → all outputs at reset values the following cycle; a new line afterwards starts at beat 0.
- Parameter sweep LINELEN=64, BEATLEN=64 → one beat per line, BeatLast on every beat, BeatCount=0 throughout.
